// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with per-set round-robin
// replacement, single-beat line refill and a one-set-per-cycle invalidate sweep.
module icache_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [ADDR_W-1:0]         addr_i,
  output logic                      addr_ok,
  output logic                      data_ok,
  output logic [31:0]               rdata,
  input  logic                      inv,
  output logic                      inv_done,
  output logic                      rd_req,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic                      rd_rdy,
  input  logic                      ret_valid,
  input  logic [32*LINE_WORDS-1:0]  ret_data
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WSEL_W + 2;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [WSEL_W-1:0] req_word_q;
  logic [IDX_W-1:0]  flush_idx_q;
  logic              inv_pend_q;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [PTR_W-1:0]  rr_q [SETS];

  logic [TAG_W-1:0]  tag_rd  [WAYS];
  logic [LINE_W-1:0] line_rd [WAYS];

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [WSEL_W-1:0] addr_word;
  logic              unused_addr_bits;

  logic              accept;
  logic              fill_we;
  logic              flush_go;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [31:0]       hit_word;
  logic [PTR_W-1:0]  vict_way;
  logic              vict_invalid;

  assign addr_tag         = addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx         = addr_i[OFF_W +: IDX_W];
  assign addr_word        = addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^addr_i[1:0];

  // Per-way tag and data arrays: written only in REFILL, read only on accept,
  // so a fill and a lookup read never collide.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [TAG_W-1:0]  tag_ram  [SETS];
    logic [LINE_W-1:0] data_ram [SETS];
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
      if (fill_we && (vict_way == PTR_W'(g))) begin
        tag_ram[req_idx_q]  <= req_tag_q;
        data_ram[req_idx_q] <= ret_data;
      end
      if (accept) begin
        tag_q  <= tag_ram[addr_idx];
        line_q <= data_ram[addr_idx];
      end
    end

    assign tag_rd[g]  = tag_q;
    assign line_rd[g] = line_q;
  end

  // Lowest-numbered matching way wins if more than one ever matches.
  always_comb begin
    hit_vec  = '0;
    hit      = 1'b0;
    hit_word = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][req_idx_q] && (tag_rd[w] == req_tag_q);
      if (hit_vec[w] && !hit) begin
        hit      = 1'b1;
        hit_word = line_rd[w][{req_word_q, 5'b0} +: 32];
      end
    end
  end

  always_comb begin
    vict_way     = rr_q[req_idx_q];
    vict_invalid = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[w][req_idx_q] && !vict_invalid) begin
        vict_invalid = 1'b1;
        vict_way     = PTR_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    rdata    = '0;
    inv_done = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    accept   = 1'b0;
    fill_we  = 1'b0;
    flush_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inv || inv_pend_q) begin
          flush_go = 1'b1;
          state_d  = S_FLUSH;
        end else begin
          addr_ok = rst;
          if (valid && rst) begin
            accept  = 1'b1;
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          rdata   = hit_word;
          state_d = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        rd_req  = 1'b1;
        rd_addr = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        if (rd_rdy) begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (ret_valid) begin
          fill_we = 1'b1;
          data_ok = 1'b1;
          rdata   = ret_data[{req_word_q, 5'b0} +: 32];
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_idx_q == IDX_W'(SETS - 1)) begin
          inv_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      flush_idx_q <= '0;
      inv_pend_q  <= 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      if (accept) begin
        req_tag_q  <= addr_tag;
        req_idx_q  <= addr_idx;
        req_word_q <= addr_word;
      end

      if (flush_go) begin
        flush_idx_q <= '0;
      end else if (state_q == S_FLUSH) begin
        flush_idx_q <= flush_idx_q + 1'b1;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[w][flush_idx_q] <= 1'b0;
        end
      end

      // The round-robin pointer only advances when a live line is evicted.
      if (fill_we) begin
        valid_q[vict_way][req_idx_q] <= 1'b1;
        if (!vict_invalid) begin
          rr_q[req_idx_q] <= (rr_q[req_idx_q] == PTR_W'(WAYS - 1)) ? '0
                                                                    : rr_q[req_idx_q] + 1'b1;
        end
      end

      if (state_q == S_IDLE) begin
        inv_pend_q <= 1'b0;
      end else if (inv && (state_q != S_FLUSH)) begin
        inv_pend_q <= 1'b1;
      end
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: directed vector table, flush/reset corner sequences and
// random fetches checked against an array-based cache model.
module tb_icache_nway;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned SETS       = 256;
  localparam int unsigned LINE_WORDS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         inv = 1'b0;
  logic         rd_rdy = 1'b0;
  logic         ret_valid = 1'b0;
  logic [127:0] ret_data = '0;
  logic         addr_ok, data_ok, inv_done, rd_req;
  logic [31:0]  rdata, rd_addr;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  icache_nway #(
    .WAYS(WAYS),
    .SETS(SETS),
    .LINE_WORDS(LINE_WORDS),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .addr_i(addr_i),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .rdata(rdata),
    .inv(inv),
    .inv_done(inv_done),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_rdy(rd_rdy),
    .ret_valid(ret_valid),
    .ret_data(ret_data)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (checks %0d/%0d)", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Backing memory: bijective word pattern, with one fixed word for the cold-miss case.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return {a[15:0] ^ a[31:16], ~a[15:0]};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int unsigned k = 0; k < LINE_WORDS; k++)
      l[k*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(k * 4));
    return l;
  endfunction

  // Reference model: per-set way contents and replacement pointer.
  bit          m_valid [SETS][WAYS];
  logic [19:0] m_tag   [SETS][WAYS];
  int unsigned m_rr    [SETS];

  function automatic bit model_access(input logic [31:0] a);
    int unsigned s = a[11:4];
    logic [19:0] t = a[31:12];
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = int'(m_rr[s]);
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endfunction

  // CPU + bridge side of one fetch; starts and ends just after a rising edge.
  task automatic fetch(input logic [31:0] a, input int unsigned rdy_dly,
                       input int unsigned ret_dly, input bit inv_mid,
                       output bit missed, output logic [31:0] data);
    int unsigned cyc = 0;
    missed = 1'b0;
    data   = '0;
    valid  = 1'b1;
    addr_i = a;
    @(negedge clk);
    while (!addr_ok && cyc < 600) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    chk("accept", 64'(addr_ok), 64'd1);
    tick();
    valid  = 1'b0;
    addr_i = $urandom;
    @(negedge clk);
    if (data_ok) begin
      data = rdata;
      chk("hit_no_rd_req", 64'(rd_req), 64'd0);
      tick();
    end else begin
      missed = 1'b1;
      chk("lookup_rdata_zero", 64'(rdata), 64'd0);
      tick();
      @(negedge clk);
      chk("miss_rd_req", {rd_req, rd_addr}, {1'b1, a[31:4], 4'h0});
      for (int unsigned i = 0; i < rdy_dly; i++) begin
        tick();
        @(negedge clk);
        chk("rd_hold", {rd_req, rd_addr}, {1'b1, a[31:4], 4'h0});
      end
      rd_rdy = 1'b1;
      tick();
      rd_rdy = 1'b0;
      if (inv_mid) inv = 1'b1;
      for (int unsigned i = 0; i < ret_dly; i++) begin
        @(negedge clk);
        chk("refill_wait", {rd_req, data_ok}, 64'd0);
        tick();
        inv = 1'b0;
      end
      ret_valid = 1'b1;
      ret_data  = line_of(a);
      @(negedge clk);
      chk("refill_data_ok", 64'(data_ok), 64'd1);
      data = rdata;
      tick();
      ret_valid = 1'b0;
      ret_data  = '0;
      inv       = 1'b0;
    end
  endtask

  // Pulse inv in IDLE; a second inv mid-sweep must be ignored.
  task automatic flush_check;
    int unsigned dones = 0, done_at = 0, ok_seen = 0;
    inv = 1'b1;
    @(negedge clk);
    chk("inv_blocks_accept", 64'(addr_ok), 64'd0);
    tick();
    inv = 1'b0;
    for (int unsigned i = 0; i < SETS; i++) begin
      if (i == 100) inv = 1'b1;
      @(negedge clk);
      if (addr_ok) ok_seen++;
      if (inv_done) begin
        dones++;
        done_at = i;
      end
      tick();
      inv = 1'b0;
    end
    chk("flush_addr_ok_low", 64'(ok_seen), 64'd0);
    chk("inv_done_count", 64'(dones), 64'd1);
    chk("inv_done_cycle", 64'(done_at), 64'(SETS - 1));
    @(negedge clk);
    chk("idle_after_flush", {addr_ok, inv_done}, 64'b10);
    tick();
    model_flush();
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_miss;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    bit          m;
    logic [31:0] d;
    logic [31:0] a;
    bit          exp_hit;
    bit          found;

    // Set 0 walk: cold miss, hits, fill to 4 ways, then round-robin evictions.
    vecs.push_back('{32'h0000_1004, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_100C, 1'b0, 32'h100C_EFF3});
    vecs.push_back('{32'h0000_2008, 1'b1, 32'h2008_DFF7});
    vecs.push_back('{32'h0000_1000, 1'b0, 32'h1000_EFFF});
    vecs.push_back('{32'h0000_3000, 1'b1, 32'h3000_CFFF});
    vecs.push_back('{32'h0000_4000, 1'b1, 32'h4000_BFFF});
    vecs.push_back('{32'h0000_5004, 1'b1, 32'h5004_AFFB});
    vecs.push_back('{32'h0000_2000, 1'b0, 32'h2000_DFFF});
    vecs.push_back('{32'h0000_1004, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_2000, 1'b1, 32'h2000_DFFF});
    vecs.push_back('{32'h0000_4004, 1'b0, 32'h4004_BFFB});
    vecs.push_back('{32'h0000_5000, 1'b0, 32'h5000_AFFF});
    vecs.push_back('{32'h0000_3000, 1'b1, 32'h3000_CFFF});
    vecs.push_back('{32'h0000_4000, 1'b1, 32'h4000_BFFF});
    vecs.push_back('{32'h0000_1008, 1'b0, 32'h1008_EFF7});
    vecs.push_back('{32'h0000_1014, 1'b1, 32'h1014_EFEB});

    model_reset();

    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {addr_ok, data_ok, inv_done, rd_req}, 64'd0);
    chk("rst_buses", {rdata, rd_addr}, 64'd0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_addr_ok", 64'(addr_ok), 64'd1);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      fetch(vecs[i].addr, (i == 0) ? 3 : $urandom_range(0, 2), 1, 1'b0, m, d);
      chk($sformatf("vec%0d_miss", i), 64'(m), 64'(vecs[i].exp_miss));
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_data));
      void'(model_access(vecs[i].addr));
    end

    flush_check();
    fetch(32'h0000_1004, 1, 1, 1'b0, m, d);
    chk("post_flush_miss", 64'(m), 64'd1);
    chk("post_flush_data", 64'(d), 64'hDEAD_BEEF);
    void'(model_access(32'h0000_1004));

    // inv during refill: fetch completes, then the pending flush runs.
    fetch(32'h0000_7008, 2, 2, 1'b1, m, d);
    chk("inv_mid_miss", 64'(m), 64'd1);
    chk("inv_mid_data", 64'(d), 64'(mem_word(32'h0000_7008)));
    @(negedge clk);
    chk("pending_blocks_accept", 64'(addr_ok), 64'd0);
    tick();
    found = 1'b0;
    for (int unsigned i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (inv_done) found = 1'b1;
      tick();
    end
    chk("pending_flush_done", 64'(found), 64'd1);
    model_flush();
    fetch(32'h0000_7008, 0, 0, 1'b0, m, d);
    chk("after_pending_flush_miss", 64'(m), 64'd1);

    // Reset in the middle of a refill.
    fetch(32'h0000_1004, 0, 0, 1'b0, m, d);
    fetch(32'h0000_1008, 0, 0, 1'b0, m, d);
    chk("pre_reset_hit", 64'(m), 64'd0);
    valid  = 1'b1;
    addr_i = 32'h0000_8004;
    tick();
    valid = 1'b0;
    tick();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", {addr_ok, data_ok, rd_req}, 64'd0);
    ret_valid = 1'b1;
    ret_data  = line_of(32'h0000_8004);
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("ret_valid_ignored", {data_ok, addr_ok}, 64'b01);
    tick();
    ret_valid = 1'b0;
    ret_data  = '0;
    model_reset();
    fetch(32'h0000_1004, 0, 1, 1'b0, m, d);
    chk("post_reset_miss", 64'(m), 64'd1);
    chk("post_reset_data", 64'(d), 64'hDEAD_BEEF);
    void'(model_access(32'h0000_1004));
    fetch(32'h0000_8004, 0, 1, 1'b0, m, d);
    chk("ignored_fill_miss", 64'(m), 64'd1);
    void'(model_access(32'h0000_8004));

    // Random fetches over a few sets and tags to mix hits, evictions and flushes.
    for (int unsigned it = 0; it < 200; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        flush_check();
      end else begin
        a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
        exp_hit = model_access(a);
        fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, m, d);
        chk($sformatf("rand%0d_miss@%h", it, a), 64'(m), 64'(!exp_hit));
        chk($sformatf("rand%0d_data@%h", it, a), 64'(d), 64'(mem_word(a)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
